// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one write port into a config register bank between APB (req0) and hardware (req1).
// Enable pulse one cycle after grant, ack 2+SETTLE_CYCLES cycles after grant; requesters hold req until acked.
module reg_write_arbiter #(
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  output logic                  ack0_o,
  input  logic                  req1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  ack1_o,
  output logic                  err_o,
  output logic [NUM_REGS-1:0]   reg_en_o,
  output logic [DATA_WIDTH-1:0] reg_d_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_ACK    = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0] NUM_REGS_L = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [3:0]          SETTLE_L   = 4'(SETTLE_CYCLES);
  localparam logic [NUM_REGS-1:0] EN_ONE     = NUM_REGS'(1);

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  errf_q, errf_d;

  logic [NUM_REGS-1:0]   reg_en_q, reg_en_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  in_range_q;
  logic                  in_range_d;

  assign in_range_q = {1'b0, addr_q} < NUM_REGS_L;
  assign in_range_d = {1'b0, addr_d} < NUM_REGS_L;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    errf_d  = errf_q;
    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          // Under contention the requester not served last time wins.
          gnt_d   = (req0_i && req1_i) ? ~last_q : req1_i;
          last_d  = gnt_d;
          addr_d  = gnt_d ? addr1_i : addr0_i;
          data_d  = gnt_d ? data1_i : data0_i;
          errf_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        errf_d  = ~in_range_q;
        cnt_d   = 4'd1;
        state_d = (SETTLE_CYCLES == 0) ? S_ACK : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_L) begin
          cnt_d   = 4'd0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are precomputed from next state so every output leaves a flop.
  always_comb begin
    reg_en_d = '0;
    if (state_d == S_ISSUE && in_range_d) begin
      reg_en_d = EN_ONE << addr_d;
    end
    ack0_d = (state_d == S_ACK) && !gnt_d;
    ack1_d = (state_d == S_ACK) && gnt_d;
    err_d  = (state_d == S_ACK) && errf_d;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= 4'd0;
      errf_q   <= 1'b0;
      reg_en_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      errf_q   <= errf_d;
      reg_en_q <= reg_en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign reg_en_o = reg_en_q;
  assign reg_d_o  = data_q;
  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: three instances (SETTLE_CYCLES 1, 0, 4); instance 0 is scoreboarded against a transaction-level model.
module tb_reg_write_arbiter;

  localparam int S0 = 1;

  logic clk = 1'b0;
  logic rst_n;

  logic        rq [3][2];
  logic [3:0]  ad [3][2];
  logic [31:0] dt [3][2];
  wire         ak [3][2];
  wire         er [3];
  wire  [7:0]  en [3];
  wire  [31:0] rd [3];
  wire         bz [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [7:0] en; logic [31:0] d; } en_t;
  typedef struct { int cyc; logic id; logic err; } ack_t;
  en_t  en_q [$];
  ack_t ack_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    reg_write_arbiter #(
      .NUM_REGS(8), .ADDR_WIDTH(4), .DATA_WIDTH(32),
      .SETTLE_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 4)
    ) u_dut (
      .clk_i(clk), .arst_ni(rst_n),
      .req0_i(rq[g][0]), .addr0_i(ad[g][0]), .data0_i(dt[g][0]), .ack0_o(ak[g][0]),
      .req1_i(rq[g][1]), .addr1_i(ad[g][1]), .data1_i(dt[g][1]), .ack1_o(ak[g][1]),
      .err_o(er[g]), .reg_en_o(en[g]), .reg_d_o(rd[g]), .busy_o(bz[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a grant occupies the port for 3+S0 cycles; contention alternates.
  initial begin : model
    int   hold;
    bit   last;
    bit   w;
    logic [3:0] a;
    hold = 0;
    last = 1'b1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        en_q.delete();
        ack_q.delete();
        hold = 0;
        last = 1'b1;
        cyc  = 0;
      end else begin
        cyc++;
        if (hold > 0) begin
          hold--;
        end else if (rq[0][0] || rq[0][1]) begin
          w    = (rq[0][0] && rq[0][1]) ? !last : rq[0][1];
          last = w;
          a    = ad[0][w];
          if (a < 8) en_q.push_back('{cyc, 8'(1) << a, dt[0][w]});
          ack_q.push_back('{cyc + 1 + S0, w, (a >= 8)});
          hold = 2 + S0;
        end
      end
    end
  end

  initial begin : monitor
    en_t  e;
    ack_t k;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("invariant_onehot_acks", ($countones(en[0]) > 1) || (ak[0][0] && ak[0][1]), 0);
        while (en_q.size() > 0 && en_q[0].cyc < cyc) begin
          e = en_q.pop_front();
          chk("missing_en_pulse", 0, e.en);
        end
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
          k = ack_q.pop_front();
          chk("missing_ack_cycle", cyc, k.cyc);
        end
        if (en[0] != 8'h00) begin
          if (en_q.size() == 0 || en_q[0].cyc != cyc) begin
            chk("unexpected_en_pulse", en[0], 0);
          end else begin
            e = en_q.pop_front();
            chk("en_value", en[0], e.en);
            chk("en_data", rd[0], e.d);
          end
        end
        if (ak[0][0] || ak[0][1]) begin
          if (ack_q.size() == 0 || ack_q[0].cyc != cyc) begin
            chk("unexpected_ack", {ak[0][1], ak[0][0]}, 0);
          end else begin
            k = ack_q.pop_front();
            chk("ack_id", ak[0][1], k.id);
            chk("ack_err", er[0], k.err);
          end
        end else if (er[0]) begin
          chk("err_without_ack", er[0], 0);
        end
      end
    end
  end

  task automatic wait_ack(input int g, input int id);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ak[g][id]) break;
    end
    chk("ack_timeout", ak[g][id], 1);
    @(posedge clk); #1;
  endtask

  task automatic rand_driver(input int id, input int n);
    for (int t = 0; t < n; t++) begin
      int idle;
      idle = $urandom_range(0, 2);
      repeat (idle) begin @(posedge clk); #1; end
      rq[0][id] = 1'b1;
      ad[0][id] = 4'($urandom_range(0, 11));
      dt[0][id] = $urandom;
      wait_ack(0, id);
      rq[0][id] = 1'b0;
    end
  endtask

  // One isolated request on instance g (settle s); called at posedge+1 with the DUT idle.
  task automatic single(input int g, input int s, input int id, input logic [3:0] a, input logic [31:0] d);
    int en_cnt, en_at, ack_at, bz_cnt;
    logic e_at_ack, other;
    logic [7:0] en_val;
    logic [31:0] d_val;
    en_cnt = 0; en_at = -1; ack_at = -1; bz_cnt = 0;
    e_at_ack = 1'b0; other = 1'b0; en_val = '0; d_val = '0;
    rq[g][id] = 1'b1; ad[g][id] = a; dt[g][id] = d;
    for (int k = 0; k < s + 6; k++) begin
      @(negedge clk);
      if (en[g] != 8'h00) begin en_cnt++; en_at = k; en_val = en[g]; d_val = rd[g]; end
      if (bz[g]) bz_cnt++;
      if (ak[g][id]) begin ack_at = k; e_at_ack = er[g]; end
      if (ak[g][1-id]) other = 1'b1;
      @(posedge clk); #1;
      if (ack_at == k) rq[g][id] = 1'b0;
    end
    chk($sformatf("single%0d_ack_cycle", g), ack_at, 2 + s);
    chk($sformatf("single%0d_err", g), e_at_ack, (a >= 8));
    chk($sformatf("single%0d_busy_cycles", g), bz_cnt, 2 + s);
    chk($sformatf("single%0d_en_pulse_width", g), en_cnt, (a < 8) ? 1 : 0);
    chk($sformatf("single%0d_wrong_ack", g), other, 0);
    if (a < 8) begin
      chk($sformatf("single%0d_en_cycle", g), en_at, 1);
      chk($sformatf("single%0d_en_value", g), en_val, 8'(1) << a);
      chk($sformatf("single%0d_reg_d", g), d_val, d);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int ids [6];
    int cycs [6];
    int n, first_id, first_k, second_k;
    logic g0, g1;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 2; i++) begin
        rq[g][i] = 1'b0; ad[g][i] = '0; dt[g][i] = '0;
      end
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", en[0], 0);
    chk("rst_ack0", ak[0][0], 0);
    chk("rst_ack1", ak[0][1], 0);
    chk("rst_err", er[0], 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_reg_d", rd[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;

    single(0, 1, 0, 4'd3, 32'hA5A5_0001);
    single(1, 0, 0, 4'd5, 32'h1234_5678);
    single(2, 4, 1, 4'd7, 32'hDEAD_BEEF);
    single(0, 1, 1, 4'd9, 32'h0BAD_0BAD);

    // Contention straight after reset, both requesters re-requesting immediately.
    do_reset();
    rq[0][0] = 1'b1; ad[0][0] = 4'd1; dt[0][0] = 32'h1111_0000;
    rq[0][1] = 1'b1; ad[0][1] = 4'd2; dt[0][1] = 32'h2222_0000;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      g0 = ak[0][0]; g1 = ak[0][1];
      if (g0 || g1) begin ids[n] = g1 ? 1 : 0; cycs[n] = k; n++; end
      @(posedge clk); #1;
      if (g0 || g1) begin
        ad[0][g1] = 4'($urandom_range(0, 7));
        dt[0][g1] = $urandom;
      end
    end
    rq[0][0] = 1'b0; rq[0][1] = 1'b0;
    chk("contention_count", n, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("contention_id%0d", i), ids[i], i % 2);
      chk($sformatf("contention_cycle%0d", i), cycs[i], 3 + 4 * i);
    end

    // Reset during SETTLE: last grant was requester 1, requester 0 takes this one.
    @(posedge clk); #1;
    rq[0][0] = 1'b1; ad[0][0] = 4'd4; dt[0][0] = 32'h4444_4444;
    rq[0][1] = 1'b1; ad[0][1] = 4'd6; dt[0][1] = 32'h6666_6666;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (en[0] != 8'h00) break;
    end
    chk("midrst_pre_en", en[0], 8'h10);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en", en[0], 0);
    chk("midrst_ack0", ak[0][0], 0);
    chk("midrst_ack1", ak[0][1], 0);
    chk("midrst_err", er[0], 0);
    chk("midrst_busy", bz[0], 0);
    chk("midrst_reg_d", rd[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    first_id = -1; first_k = -1; second_k = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      g0 = ak[0][0]; g1 = ak[0][1];
      if ((g0 || g1) && first_id >= 0 && second_k < 0) second_k = k;
      if ((g0 || g1) && first_id < 0) begin first_id = g1 ? 1 : 0; first_k = k; end
      @(posedge clk); #1;
      if (g0) rq[0][0] = 1'b0;
      if (g1) rq[0][1] = 1'b0;
    end
    chk("midrst_first_winner", first_id, 0);
    chk("midrst_first_ack_cycle", first_k, 3);
    chk("midrst_second_ack_cycle", second_k, 7);

    fork
      rand_driver(0, 150);
      rand_driver(1, 150);
    join
    repeat (20) @(posedge clk);
    #1;
    chk("drain_en_queue", en_q.size(), 0);
    chk("drain_ack_queue", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one write port into a bank of NUM_REGS load-enabled configuration registers (UART config/CSR bank) between two requesters.
- Requester 0 is the APB bus write path; requester 1 is internal hardware (status/auto-update logic).
- Arbitrates round-robin, drives one-hot load enables plus shared data into the bank, and waits a settle window for two-stage bank registers before acknowledging.
- Out-of-range addresses complete with an error flag and no write.

Parameters:
- NUM_REGS, 8, number of registers in the bank (1..2**ADDR_WIDTH).
- ADDR_WIDTH, 4, width of requester address buses.
- DATA_WIDTH, 32, register data width.
- SETTLE_CYCLES, 1, idle cycles after the write pulse before ack (0..15).

Ports:
- clk_i  input  1  clock, all state on posedge.
- arst_ni  input  1  asynchronous active-low reset.
- req0_i  input  1  requester 0 (APB) write request; held until acked.
- addr0_i  input  ADDR_WIDTH  requester 0 register index.
- data0_i  input  DATA_WIDTH  requester 0 write data.
- ack0_o  output  1  one-cycle completion pulse to requester 0.
- req1_i  input  1  requester 1 (hardware) write request; held until acked.
- addr1_i  input  ADDR_WIDTH  requester 1 register index.
- data1_i  input  DATA_WIDTH  requester 1 write data.
- ack1_o  output  1  one-cycle completion pulse to requester 1.
- err_o  output  1  valid with ack: address >= NUM_REGS, no write performed.
- reg_en_o  output  NUM_REGS  one-hot load enables to bank.
- reg_d_o  output  DATA_WIDTH  shared write data to bank.
- busy_o  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, arst_ni low):
  - State goes to IDLE; all outputs are 0.
  - Latched addr/data are cleared to 0; settle counter is cleared.
  - last_grant = 1, so requester 0 wins the first contention.
  - Reset mid-operation aborts the transaction: no ack is given and a pending write pulse is dropped.
- Handshake:
  - A requester holds req/addr/data stable from assertion until the clock edge at which its ack is high.
  - It deasserts req (or presents a new request) after that edge.
  - Inputs are sampled only in IDLE; changes while busy are ignored.
- State IDLE:
  - If no req, stay.
  - If exactly one req, grant it.
  - If both req, grant the requester opposite last_grant.
  - On grant: latch winner id, addr, data; update last_grant; go to ISSUE.
- State ISSUE (exactly 1 cycle):
  - If latched addr < NUM_REGS, reg_en_o = 1 << addr; otherwise reg_en_o = 0 and set an internal error flag.
  - Next state is SETTLE if SETTLE_CYCLES > 0, else ACK.
- State SETTLE:
  - reg_en_o = 0; counter counts 1..SETTLE_CYCLES, then go to ACK.
- State ACK (exactly 1 cycle):
  - ackN_o = 1 for the latched winner only.
  - err_o = internal error flag; next state IDLE.
- reg_d_o:
  - Equals the latched data in all states; holds its last value in IDLE.
  - All outputs are registered (no combinational input-to-output paths).
- Latency:
  - req seen in IDLE at cycle 0 → enable pulse in cycle 1 → ack in cycle 2+SETTLE_CYCLES.
  - Minimum request-to-request spacing is 3+SETTLE_CYCLES cycles.
- Bounds and corner cases:
  - At most one reg_en_o bit is ever high.
  - ack0_o and ack1_o are never both high.
  - Fairness: under continuous contention, grants strictly alternate.
  - A requester re-asserting immediately after its ack still loses to a waiting opposite requester.

Test Plan:
- Single write: req0, addr0=3, data0=0xA5A5_0001, SETTLE=1 → reg_en_o=0x08 with reg_d_o=0xA5A5_0001 in cycle 1; ack0_o in cycle 3; err_o=0; busy_o high during cycles 1–3.
- Contention after reset: req0 and req1 both high (addr 1 and 2) → req0 served first (reg_en_o=0x02), then req1 (reg_en_o=0x04); acks in cycles 3 and 7.
- Continuous contention: both requesters re-request immediately for 6 transactions → grant order 0,1,0,1,0,1, no back-to-back grants to the same requester.
- Out of range: req1, addr1=9, NUM_REGS=8 → reg_en_o stays 0 throughout; ack1_o=1 together with err_o=1 in cycle 3.
- Settle variants: SETTLE_CYCLES=0 → ack in cycle 2; SETTLE_CYCLES=4 → ack in cycle 6; the enable pulse is always exactly 1 cycle wide.
- Reset mid-operation: assert arst_ni low during SETTLE → all outputs 0 immediately, no ack. After release with req0 and req1 both still high, req0 wins first.
